control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit for the datapath; it produces every control signal the datapath consumes.
- It replaces the hand-driven T-state stimulus with a synthesizable Moore FSM.
- It fetches an instruction, decodes the opcode from the IR contents, and steps through one execute sequence per instruction class.
- Each T-state lasts exactly one clock cycle.

Parameters:
- OP_LD, 5'b00000, load opcode
- OP_LDI, 5'b00001, load-immediate opcode
- OP_ST, 5'b00010, store opcode
- OP_ADD, 5'b00011, add opcode
- OP_SUB, 5'b00100, subtract opcode
- OP_AND, 5'b00101, and opcode
- OP_OR, 5'b00110, or opcode
- OP_HALT, 5'b11011, halt opcode
- ALU_ADD, 6'd13, ALU_Sel code for add
- ALU_SUB, 6'd14, ALU_Sel code for subtract
- ALU_AND, 6'd1, ALU_Sel code for and
- ALU_OR, 6'd2, ALU_Sel code for or

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- clr  in  1  reset, synchronous, active-high
- stop  in  1  request to halt at the next instruction boundary
- ir  in  32  IR contents; opcode is ir[31:27]
- enc_input  out  32  one-hot bus-source select: 19=Zlow, 20=PC, 22=MDR, 23=MAR, 25=C
- reg_enable  out  32  register load enables: 19=Zlow, 21=IR, 22=MDR, 23=MAR, 24=Y
- incPC  out  1  PC increment strobe
- read  out  1  memory read; MDR loads Mdatain when asserted
- write  out  1  memory write strobe
- Gra, Grb, Grc  out  1 each  register-field selects
- Rin, Rout, BAout  out  1 each  register-file in/out controls
- ALU_Sel  out  6  ALU operation
- run  out  1  high while executing

Behaviour:
- Reset and output timing:
  - clr=1 at a rising edge forces state RST regardless of the current state, including mid-instruction.
  - All outputs are decoded combinationally from the present state only (Moore).
  - Every control output is 0 in RST and HALTED; enc_input=0, reg_enable=0, ALU_Sel=0.
  - Any signal not listed for a state below is 0 in that state.
- States: RST, T0-T7, HALTED. Only the transitions listed here exist.
  - RST -> T0 when clr=0.
  - T0: enc_input[20], reg_enable[23], incPC.
  - T1: read, reg_enable[22].
  - T2: enc_input[22], reg_enable[21].
  - T2 -> T3 for any implemented opcode. For an unimplemented opcode: T2 -> T0 (no-op), or T2 -> HALTED when stop=1.
  - T2 -> HALTED when opcode=OP_HALT; the IR value at the T2->T3 edge is the decode point.
- Execute, ld/ldi/st:
  - T3: Grb, BAout, reg_enable[24].
  - T4: enc_input[25], ALU_Sel=ALU_ADD, reg_enable[19].
  - ldi T5: enc_input[19], Gra, Rin; then -> T0.
  - ld T5: enc_input[19], reg_enable[23].
  - ld T6: read, reg_enable[22].
  - ld T7: enc_input[22], Gra, Rin; then -> T0.
  - st T5: enc_input[19], reg_enable[23].
  - st T6: Gra, Rout, reg_enable[22], with read=0.
  - st T7: write; then -> T0.
- Execute, add/sub/and/or:
  - T3: Grb, Rout, reg_enable[24].
  - T4: Grc, Rout, reg_enable[19], ALU_Sel = matching parameter.
  - T5: enc_input[19], Gra, Rin; then -> T0.
- Instruction latency (T0 to last execute state):
  - ldi/ALU: 6 cycles.
  - ld/st: 8 cycles.
  - no-op: 3 cycles.
- Stop and halt:
  - On any edge that would enter T0 from a final execute state, stop=1 sends the FSM to HALTED instead.
  - stop arriving mid-instruction lets the instruction complete.
  - HALTED is left only via clr.
- run = 1 in T0-T7, 0 in RST and HALTED.
- Invariants:
  - enc_input is one-hot or zero in every state.
  - read and write are never both 1.
- The opcode is held in a register latched at T2 so later IR changes cannot alter the sequence.

Test Plan:
- clr=1 for 2 cycles, then 0, with ir=0x08800065 (ldi R1, 0x65): RST, then T0 asserts enc_input=0x00100000, reg_enable=0x00800000, incPC=1. T3 has Grb=BAout=1 and reg_enable=0x01000000. T4 has ALU_Sel=13 and enc_input=0x02000000. T5 has enc_input=0x00080000, Gra=Rin=1. T0 recurs 6 cycles after the first T0.
- ir=0x00800010 (ld): T6 has read=1 and reg_enable=0x00400000. T7 has enc_input=0x00400000 and Rin=1. Next T0 comes 8 cycles after T0.
- ir=0x10800010 (st): T6 has Rout=1, reg_enable[22]=1, read=0. T7 has write=1 only. T0 follows.
- ir=0x19000000 (add R2, R0, R0): T4 has Grc=Rout=1 and ALU_Sel=13. ir=0x21000000 (sub): T4 ALU_Sel=14.
- stop=1 pulsed during T4 of ldi: T5 completes, then HALTED with run=0 and all outputs 0. The FSM stays HALTED for 20 cycles.
- clr asserted in T6 of ld: the next state is RST with all outputs 0. Also ir=0xF8000000 (unimplemented): T2 -> T0 and nothing asserted after T2.

Source files
------------

// File: rtl/control_sequencer.sv
// ============================================================================
//  Module   : control_sequencer
//  Purpose  : Hardwired Moore control unit: fetch, decode, execute sequencing
//             for the datapath (one T-state per clock).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer #(
  parameter logic [4:0] OP_LD   = 5'b00000,
  parameter logic [4:0] OP_LDI  = 5'b00001,
  parameter logic [4:0] OP_ST   = 5'b00010,
  parameter logic [4:0] OP_ADD  = 5'b00011,
  parameter logic [4:0] OP_SUB  = 5'b00100,
  parameter logic [4:0] OP_AND  = 5'b00101,
  parameter logic [4:0] OP_OR   = 5'b00110,
  parameter logic [4:0] OP_HALT = 5'b11011,
  parameter logic [5:0] ALU_ADD = 6'd13,
  parameter logic [5:0] ALU_SUB = 6'd14,
  parameter logic [5:0] ALU_AND = 6'd1,
  parameter logic [5:0] ALU_OR  = 6'd2
) (
  input  logic        clock,
  input  logic        clr,
  input  logic        stop,
  input  logic [31:0] ir,
  output logic [31:0] enc_input,
  output logic [31:0] reg_enable,
  output logic        incPC,
  output logic        read,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [5:0]  ALU_Sel,
  output logic        run
);

  localparam int ZLOW = 19;
  localparam int PC   = 20;
  localparam int IR   = 21;
  localparam int MDR  = 22;
  localparam int MAR  = 23;
  localparam int Y    = 24;
  localparam int C    = 25;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_T7     = 4'd8,
    S_HALTED = 4'd9
  } state_t;

  state_t     state, state_next;
  logic [4:0] opcode;
  logic       stop_pending;
  logic [4:0] ir_op;
  logic       op_is_alu;
  logic       op_is_two_step;
  logic       ir_op_known;
  state_t     boundary;
  logic [5:0] alu_code;
  logic       unused_ir_bits;

  assign ir_op          = ir[31:27];
  assign unused_ir_bits = ^ir[26:0];

  assign op_is_alu      = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                          (opcode == OP_AND) || (opcode == OP_OR);
  assign op_is_two_step = (opcode == OP_LD) || (opcode == OP_ST);
  assign ir_op_known    = (ir_op == OP_LD)  || (ir_op == OP_LDI) ||
                          (ir_op == OP_ST)  || (ir_op == OP_ADD) ||
                          (ir_op == OP_SUB) || (ir_op == OP_AND) ||
                          (ir_op == OP_OR);

  // A stop request is remembered so a short pulse mid-instruction still halts
  // at the next instruction boundary.
  assign boundary = (stop || stop_pending) ? S_HALTED : S_T0;

  always_comb begin
    alu_code = ALU_ADD;
    case (opcode)
      OP_SUB:  alu_code = ALU_SUB;
      OP_AND:  alu_code = ALU_AND;
      OP_OR:   alu_code = ALU_OR;
      default: alu_code = ALU_ADD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      state        <= S_RST;
      stop_pending <= 1'b0;
      opcode       <= OP_LD;
    end else begin
      state <= state_next;
      if (stop) stop_pending <= 1'b1;
      if (state == S_T2) opcode <= ir_op;
    end
  end

  always_comb begin
    state_next = state;
    enc_input  = '0;
    reg_enable = '0;
    incPC      = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    BAout      = 1'b0;
    ALU_Sel    = '0;
    run        = (state != S_RST) && (state != S_HALTED);

    case (state)
      S_RST: state_next = S_T0;
      S_T0: begin
        enc_input[PC]   = 1'b1;
        reg_enable[MAR] = 1'b1;
        incPC           = 1'b1;
        state_next      = S_T1;
      end
      S_T1: begin
        read            = 1'b1;
        reg_enable[MDR] = 1'b1;
        state_next      = S_T2;
      end
      S_T2: begin
        enc_input[MDR] = 1'b1;
        reg_enable[IR] = 1'b1;
        if (ir_op == OP_HALT)  state_next = S_HALTED;
        else if (ir_op_known)  state_next = S_T3;
        else                   state_next = boundary;
      end
      S_T3: begin
        Grb           = 1'b1;
        reg_enable[Y] = 1'b1;
        if (op_is_alu) Rout  = 1'b1;
        else           BAout = 1'b1;
        state_next = S_T4;
      end
      S_T4: begin
        reg_enable[ZLOW] = 1'b1;
        if (op_is_alu) begin
          Grc     = 1'b1;
          Rout    = 1'b1;
          ALU_Sel = alu_code;
        end else begin
          enc_input[C] = 1'b1;
          ALU_Sel      = ALU_ADD;
        end
        state_next = S_T5;
      end
      S_T5: begin
        enc_input[ZLOW] = 1'b1;
        if (op_is_two_step) begin
          reg_enable[MAR] = 1'b1;
          state_next      = S_T6;
        end else begin
          Gra        = 1'b1;
          Rin        = 1'b1;
          state_next = boundary;
        end
      end
      S_T6: begin
        reg_enable[MDR] = 1'b1;
        if (opcode == OP_LD) begin
          read = 1'b1;
        end else begin
          Gra  = 1'b1;
          Rout = 1'b1;
        end
        state_next = S_T7;
      end
      S_T7: begin
        if (opcode == OP_LD) begin
          enc_input[MDR] = 1'b1;
          Gra            = 1'b1;
          Rin            = 1'b1;
        end else begin
          write = 1'b1;
        end
        state_next = boundary;
      end
      S_HALTED: state_next = S_HALTED;
      default:  state_next = S_RST;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
//  Module   : tb_control_sequencer
//  Purpose  : Self-checking bench for control_sequencer: queue-based control
//             word model plus directed literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clr;
  logic        stop;
  logic [31:0] ir;
  logic [31:0] enc_input, reg_enable;
  logic        incPC, read, write, Gra, Grb, Grc, Rin, Rout, BAout, run;
  logic [5:0]  ALU_Sel;

  int checks = 0;
  int errors = 0;

  control_sequencer dut (
    .clock(clock), .clr(clr), .stop(stop), .ir(ir),
    .enc_input(enc_input), .reg_enable(reg_enable),
    .incPC(incPC), .read(read), .write(write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .ALU_Sel(ALU_Sel), .run(run)
  );

  always #5 clock = ~clock;

  // Flag order: incPC read write Gra Grb Grc Rin Rout BAout
  typedef struct packed {
    logic [31:0] enc;
    logic [31:0] en;
    logic [8:0]  flags;
    logic [5:0]  alu;
    logic        run;
  } ctl_t;

  localparam logic [8:0] F_INC  = 9'b100000000;
  localparam logic [8:0] F_RD   = 9'b010000000;
  localparam logic [8:0] F_WR   = 9'b001000000;
  localparam logic [8:0] F_GRA  = 9'b000100000;
  localparam logic [8:0] F_GRB  = 9'b000010000;
  localparam logic [8:0] F_GRC  = 9'b000001000;
  localparam logic [8:0] F_RIN  = 9'b000000100;
  localparam logic [8:0] F_ROUT = 9'b000000010;
  localparam logic [8:0] F_BA   = 9'b000000001;

  ctl_t act;
  assign act = {enc_input, reg_enable, incPC, read, write, Gra, Grb, Grc,
                Rin, Rout, BAout, ALU_Sel, run};

  function automatic ctl_t cw(input int src, input int dst,
                              input logic [8:0] f, input logic [5:0] alu);
    ctl_t c;
    c       = '0;
    if (src >= 0) c.enc = 32'd1 << src;
    if (dst >= 0) c.en  = 32'd1 << dst;
    c.flags = f;
    c.alu   = alu;
    c.run   = 1'b1;
    return c;
  endfunction

  // ---------------- behavioural model: queue of expected control words -----
  ctl_t       q[$];
  ctl_t       exp_w;
  logic       model_ok = 1'b0;
  logic       m_rst, m_halt, m_stop, m_dec;
  logic [4:0] m_op;

  task push_fetch();
    q.push_back(cw(20, 23, F_INC, 6'd0));
    q.push_back(cw(-1, 22, F_RD, 6'd0));
    q.push_back(cw(22, 21, 9'd0, 6'd0));
    m_dec = 1'b1;
  endtask

  task boundary();
    if (m_stop) m_halt = 1'b1;
    else        push_fetch();
  endtask

  task push_exec(input logic [4:0] op);
    logic [5:0] sel;
    case (op)
      5'd0, 5'd1, 5'd2: begin
        q.push_back(cw(-1, 24, F_GRB | F_BA, 6'd0));
        q.push_back(cw(25, 19, 9'd0, 6'd13));
        if (op == 5'd1) begin
          q.push_back(cw(19, -1, F_GRA | F_RIN, 6'd0));
        end else begin
          q.push_back(cw(19, 23, 9'd0, 6'd0));
          if (op == 5'd0) begin
            q.push_back(cw(-1, 22, F_RD, 6'd0));
            q.push_back(cw(22, -1, F_GRA | F_RIN, 6'd0));
          end else begin
            q.push_back(cw(-1, 22, F_GRA | F_ROUT, 6'd0));
            q.push_back(cw(-1, -1, F_WR, 6'd0));
          end
        end
      end
      default: begin
        sel = (op == 5'd4) ? 6'd14 : (op == 5'd5) ? 6'd1 :
              (op == 5'd6) ? 6'd2 : 6'd13;
        q.push_back(cw(-1, 24, F_GRB | F_ROUT, 6'd0));
        q.push_back(cw(-1, 19, F_GRC | F_ROUT, sel));
        q.push_back(cw(19, -1, F_GRA | F_RIN, 6'd0));
      end
    endcase
  endtask

  always @(posedge clock) begin
    if (clr) begin
      q.delete();
      m_rst    = 1'b1;
      m_halt   = 1'b0;
      m_stop   = 1'b0;
      m_dec    = 1'b0;
      exp_w    = '0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      m_stop = m_stop | stop;
      if (!m_halt) begin
        if (m_rst) begin
          m_rst = 1'b0;
          push_fetch();
        end else if (q.size() == 0) begin
          if (m_dec) begin
            m_dec = 1'b0;
            m_op  = ir[31:27];
            if (m_op == 5'b11011)  m_halt = 1'b1;
            else if (m_op <= 5'd6) push_exec(m_op);
            else                   boundary();
          end else begin
            boundary();
          end
        end
      end
      exp_w = m_halt ? '0 : q.pop_front();
    end
  end

  // ---------------- per-cycle compare ---------------------------------------
  always @(negedge clock) begin
    if (model_ok) begin
      checks++;
      if (act !== exp_w) begin
        errors++;
        $display("FAIL model_word t=%0t dut=%h required=%h", $time, act, exp_w);
      end
      checks++;
      if (!$onehot0(enc_input) || (read && write)) begin
        errors++;
        $display("FAIL invariant t=%0t enc_input=%h read=%b write=%b required onehot0 and not both",
                 $time, enc_input, read, write);
      end
    end
  end

  // ---------------- directed stimulus with literal expectations -------------
  task check(input string name, input logic [79:0] got, input logic [79:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task steps(input int n);
    repeat (n) @(negedge clock);
  endtask

  task wait_t0(input string name);
    int n;
    n = 0;
    while (incPC !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (incPC !== 1'b1) begin
      errors++;
      $display("FAIL %s: no T0 within 20 cycles, incPC=%b required 1", name, incPC);
    end
  endtask

  task reset_and_start();
    clr = 1'b1;
    steps(1);
    check("reset_outputs", 80'(act), 80'd0);
    clr = 1'b0;
    steps(1);
    wait_t0("restart");
  endtask

  initial begin
    clr  = 1'b1;
    stop = 1'b0;
    ir   = 32'h08800065;
    steps(2);
    check("rst_all_zero", 80'(act), 80'd0);
    check("rst_run", 80'(run), 80'd0);
    clr = 1'b0;
    steps(1);
    wait_t0("first_t0");

    // ldi R1, 0x65
    check("ldi_t0_enc", 80'(enc_input), 80'h00100000);
    check("ldi_t0_en", 80'(reg_enable), 80'h00800000);
    check("ldi_t0_inc", 80'(incPC), 80'd1);
    steps(3);
    check("ldi_t3", 80'({Grb, BAout, reg_enable}), {48'd0, 2'b11, 32'h01000000});
    steps(1);
    check("ldi_t4", 80'({ALU_Sel, enc_input}), {42'd0, 6'd13, 32'h02000000});
    steps(1);
    check("ldi_t5", 80'({Gra, Rin, enc_input}), {46'd0, 2'b11, 32'h00080000});
    steps(1);
    check("ldi_latency6", 80'({incPC, enc_input}), {47'd0, 1'b1, 32'h00100000});

    // ld
    ir = 32'h00800010;
    steps(6);
    check("ld_t6", 80'({read, reg_enable}), {47'd0, 1'b1, 32'h00400000});
    steps(1);
    check("ld_t7", 80'({Rin, enc_input}), {47'd0, 1'b1, 32'h00400000});
    steps(1);
    check("ld_latency8", 80'(incPC), 80'd1);

    // st
    ir = 32'h10800010;
    steps(6);
    check("st_t6", 80'({Rout, reg_enable[22], read}), 80'b110);
    steps(1);
    check("st_t7", 80'(act), 80'({64'd0, F_WR, 6'd0, 1'b1}));
    steps(1);
    check("st_next_t0", 80'(incPC), 80'd1);

    // ALU class: add, sub, and, or
    ir = 32'h19000000;
    steps(4);
    check("add_t4", 80'({Grc, Rout, ALU_Sel}), {72'd0, 2'b11, 6'd13});
    steps(2);
    ir = 32'h21000000;
    steps(4);
    check("sub_t4_alu", 80'(ALU_Sel), 80'd14);
    steps(2);
    ir = 32'h28000000;
    steps(4);
    check("and_t4_alu", 80'(ALU_Sel), 80'd1);
    steps(2);
    ir = 32'h30000000;
    steps(4);
    check("or_t4_alu", 80'(ALU_Sel), 80'd2);
    steps(2);
    check("or_next_t0", 80'(incPC), 80'd1);

    // Unimplemented opcode is a 3-cycle no-op
    ir = 32'hF8000000;
    steps(3);
    check("noop_latency3", 80'(incPC), 80'd1);

    // clr in T6 of ld
    ir = 32'h00800010;
    steps(6);
    clr = 1'b1;
    steps(1);
    check("clr_mid_ld", 80'(act), 80'd0);
    clr = 1'b0;
    steps(1);
    wait_t0("after_mid_clr");

    // Halt opcode
    ir = 32'hD8000000;
    steps(3);
    check("halt_op_run", 80'({run, act}), 80'd0);
    steps(3);
    check("halt_op_stays", 80'(run), 80'd0);
    reset_and_start();

    // Stop during an unimplemented opcode halts at T2
    ir   = 32'hF8000000;
    stop = 1'b1;
    steps(3);
    stop = 1'b0;
    check("noop_stop_halt", 80'(run), 80'd0);
    reset_and_start();

    // Stop pulsed in T4 of ldi: T5 completes, then HALTED for good
    ir = 32'h08800065;
    steps(4);
    stop = 1'b1;
    steps(1);
    stop = 1'b0;
    check("stop_t5_completes", 80'({Gra, Rin, enc_input}), {46'd0, 2'b11, 32'h00080000});
    steps(1);
    check("stop_halted", 80'({run, act}), 80'd0);
    steps(20);
    check("stop_halted_20", 80'({run, act}), 80'd0);

    steps(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
